// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: opcode encodings, predictor
// counter encodings and the branch-condition decoder.
package branch_resolve_unit_pkg;

    typedef enum logic [4:0] {
        OP_BGTZ = 5'b01000,
        OP_BLEZ = 5'b01001,
        OP_J    = 5'b01010,
        OP_BNEZ = 5'b01100,
        OP_BEQZ = 5'b01101,
        OP_BLTZ = 5'b01110,
        OP_BGEZ = 5'b01111
    } branch_op_e;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    typedef struct packed {
        logic is_branch;
        logic is_cond;
        logic taken;
    } resolve_t;

    function automatic resolve_t resolve_branch(input logic [4:0] opcode,
                                                input logic       is_zero,
                                                input logic       is_neg);
        resolve_t r;
        r = '0;
        case (branch_op_e'(opcode))
            OP_BNEZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = !is_zero;            end
            OP_BEQZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = is_zero;             end
            OP_BLTZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = is_neg;              end
            OP_BGEZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = !is_neg;             end
            OP_BGTZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = !is_neg && !is_zero; end
            OP_BLEZ: begin r.is_branch = 1'b1; r.is_cond = 1'b1; r.taken = is_neg || is_zero;   end
            OP_J:    begin r.is_branch = 1'b1; r.is_cond = 1'b0; r.taken = 1'b1;                end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] n;
        n = ctr;
        if (taken && ctr != CTR_ST) begin
            n = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            n = ctr - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating direction counters with a combinational query port
// and a single registered update port.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] taken_bits;

    // Counters are plain flops so the whole table can clear asynchronously.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
            logic [1:0] ctr_q;
            logic [1:0] ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (upd_en && upd_idx == IDX_W'(gi)) begin
                    ctr_d = ctr_next(ctr_q, upd_taken);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_q <= CTR_RESET;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign taken_bits[gi] = ctr_q[1];
        end
    endgenerate

    // Reads the registered state, so a same-cycle update is not visible yet.
    assign query_taken = taken_bits[query_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch direction against a zero compare, flags mispredictions and
// trains a small bimodal predictor on every delivered conditional branch.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PC_W  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_is_branch,
    output logic             out_mispredict,
    output logic [PC_W-1:0]  out_pc,
    input  logic [PC_W-1:0]  query_pc,
    output logic             query_taken
);

    logic            valid_q, valid_d;
    logic            taken_q, taken_d;
    logic            is_branch_q, is_branch_d;
    logic            is_cond_q, is_cond_d;
    logic            misp_q, misp_d;
    logic [PC_W-1:0] pc_q, pc_d;

    resolve_t res;
    logic     accept;
    logic     handshake;
    logic     unused_query_hi;

    assign res       = resolve_branch(in_opcode, in_operand == '0, in_operand[WIDTH-1]);
    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign handshake = valid_q && out_ready;

    always_comb begin
        valid_d     = valid_q;
        taken_d     = taken_q;
        is_branch_d = is_branch_q;
        is_cond_d   = is_cond_q;
        misp_d      = misp_q;
        pc_d        = pc_q;
        if (accept) begin
            taken_d     = res.taken;
            is_branch_d = res.is_branch;
            is_cond_d   = res.is_cond;
            misp_d      = res.is_branch && (res.taken ^ in_pred_taken);
            pc_d        = in_pc;
        end
        // Flush wins over a new request; a drained slot empties unless refilled.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            taken_q     <= 1'b0;
            is_branch_q <= 1'b0;
            is_cond_q   <= 1'b0;
            misp_q      <= 1'b0;
            pc_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            taken_q     <= taken_d;
            is_branch_q <= is_branch_d;
            is_cond_q   <= is_cond_d;
            misp_q      <= misp_d;
            pc_q        <= pc_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = taken_q;
    assign out_is_branch  = is_branch_q;
    assign out_mispredict = misp_q;
    assign out_pc         = pc_q;

    // Training is tied to delivery, so a coincident flush still trains.
    branch_history_table #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .query_idx  (query_pc[IDX_W-1:0]),
        .query_taken(query_taken),
        .upd_en     (handshake && is_cond_q),
        .upd_idx    (pc_q[IDX_W-1:0]),
        .upd_taken  (taken_q)
    );

    assign unused_query_hi = ^query_pc[PC_W-1:IDX_W];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: a table-driven opcode
// sweep plus hand-written handshake, flush, reset and predictor sequences.
module tb_branch_resolve_unit;

    localparam logic [4:0] T_BGTZ = 5'b01000;
    localparam logic [4:0] T_BLEZ = 5'b01001;
    localparam logic [4:0] T_J    = 5'b01010;
    localparam logic [4:0] T_BNEZ = 5'b01100;
    localparam logic [4:0] T_BEQZ = 5'b01101;
    localparam logic [4:0] T_BLTZ = 5'b01110;
    localparam logic [4:0] T_BGEZ = 5'b01111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [15:0] in_operand;
    logic [15:0] in_pc;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_is_branch;
    logic        out_mispredict;
    logic [15:0] out_pc;
    logic [15:0] query_pc;
    logic        query_taken;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] opnd;
        logic        exp_taken;
        logic        exp_br;
        logic        exp_misp;
    } vec_t;

    vec_t vecs [23];

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(16), .PC_W(16), .IDX_W(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_operand    (in_operand),
        .in_pc         (in_pc),
        .in_pred_taken (in_pred_taken),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_is_branch (out_is_branch),
        .out_mispredict(out_mispredict),
        .out_pc        (out_pc),
        .query_pc      (query_pc),
        .query_taken   (query_taken)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] opnd,
                         input logic [15:0] pc, input logic pred);
        in_opcode     = op;
        in_operand    = opnd;
        in_pc         = pc;
        in_pred_taken = pred;
        in_valid      = 1'b1;
        $display("txn op=%05b operand=0x%04h pc=0x%04h pred=%0b", op, opnd, pc, pred);
    endtask

    task automatic query(input string name, input logic [15:0] pc, input logic exp);
        query_pc = pc;
        #1;
        check(name, query_taken, exp);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // op, operand, expected taken, is_branch, mispredict (pred_taken=1)
        vecs[0]  = '{T_BNEZ, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{T_BNEZ, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{T_BNEZ, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{T_BEQZ, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{T_BEQZ, 16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{T_BEQZ, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{T_BLTZ, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{T_BLTZ, 16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{T_BLTZ, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{T_BGEZ, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{T_BGEZ, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{T_BGEZ, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{T_BGTZ, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{T_BGTZ, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{T_BGTZ, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{T_BLEZ, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{T_BLEZ, 16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{T_BLEZ, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{T_J,    16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{T_J,    16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{T_J,    16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{5'b11111, 16'h0000, 1'b0, 1'b0, 1'b0};

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_opcode     = '0;
        in_operand    = '0;
        in_pc         = '0;
        in_pred_taken = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b1;
        query_pc      = 16'h0003;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_taken", out_taken, 1'b0);
        check("rst_out_is_branch", out_is_branch, 1'b0);
        check("rst_out_mispredict", out_mispredict, 1'b0);
        check("rst_out_pc", out_pc, 16'h0000);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        query("post_rst_query_0003", 16'h0003, 1'b0);
        for (int q = 0; q < 16; q++) begin
            query($sformatf("post_rst_query_%0d", q), 16'(q), 1'b0);
        end

        // Latency of one cycle
        drive(T_BNEZ, 16'h0001, 16'h0020, 1'b0);
        tick();
        in_valid = 1'b0;
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_out_taken", out_taken, 1'b1);
        check("lat_out_mispredict", out_mispredict, 1'b1);
        check("lat_out_pc", out_pc, 16'h0020);
        tick();
        check("lat_drained", out_valid, 1'b0);

        // Asynchronous reset mid-operation loses the in-flight result
        out_ready = 1'b0;
        drive(T_J, 16'h0000, 16'h0044, 1'b0);
        tick();
        in_valid = 1'b0;
        check("midrst_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_pc", out_pc, 16'h0000);
        check("midrst_is_branch", out_is_branch, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;

        // Opcode sweep, back to back
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].op, vecs[i].opnd, 16'h0100 + 16'(i), 1'b1);
            tick();
            check($sformatf("sweep%0d_valid", i), out_valid, 1'b1);
            check($sformatf("sweep%0d_taken", i), out_taken, vecs[i].exp_taken);
            check($sformatf("sweep%0d_is_branch", i), out_is_branch, vecs[i].exp_br);
            check($sformatf("sweep%0d_mispredict", i), out_mispredict, vecs[i].exp_misp);
            check($sformatf("sweep%0d_pc", i), out_pc, 16'h0100 + 16'(i));
        end
        in_valid = 1'b0;
        tick();
        check("sweep_drained", out_valid, 1'b0);

        // Predictor training on index 3
        do_reset();
        out_ready = 1'b1;
        query_pc  = 16'h0003;
        drive(T_BEQZ, 16'h0000, 16'h0013, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bht_a_mispredict", out_mispredict, 1'b1);
        check("bht_a_taken", out_taken, 1'b1);
        query("bht_a_pre_update", 16'h0003, 1'b0);
        tick();
        query("bht_a_post_update", 16'h0003, 1'b1);
        drive(T_BEQZ, 16'h0000, 16'h0013, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bht_b_mispredict", out_mispredict, 1'b1);
        tick();
        query("bht_b_post_update", 16'h0003, 1'b1);
        drive(T_BEQZ, 16'h0001, 16'h0003, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bht_c_taken", out_taken, 1'b0);
        check("bht_c_mispredict", out_mispredict, 1'b0);
        tick();
        query("bht_c_saturated_then_dec", 16'h0003, 1'b1);
        drive(T_BEQZ, 16'h0001, 16'h0003, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        query("bht_d_second_dec", 16'h0003, 1'b0);

        // Backpressure with a second request pending
        do_reset();
        out_ready = 1'b0;
        drive(T_J, 16'h0000, 16'h00A1, 1'b0);
        tick();
        drive(T_BGEZ, 16'h8000, 16'h00A2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
            check($sformatf("bp%0d_out_valid", c), out_valid, 1'b1);
            check($sformatf("bp%0d_out_pc", c), out_pc, 16'h00A1);
            check($sformatf("bp%0d_out_taken", c), out_taken, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_first_pc", out_pc, 16'h00A1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_pc", out_pc, 16'h00A2);
        check("bp_second_taken", out_taken, 1'b0);
        check("bp_second_mispredict", out_mispredict, 1'b1);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Flush without handshake: result and pending request both dropped
        do_reset();
        out_ready = 1'b0;
        drive(T_BNEZ, 16'h0001, 16'h0007, 1'b0);
        tick();
        drive(T_BNEZ, 16'h0001, 16'h0007, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (2) tick();
        check("flush_still_empty", out_valid, 1'b0);
        query("flush_bht_unchanged", 16'h0007, 1'b0);

        // Flush coincident with a handshake still trains; the new request is dropped
        drive(T_BNEZ, 16'h0001, 16'h0005, 1'b0);
        tick();
        drive(T_BNEZ, 16'h0001, 16'h0006, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_hs_out_valid", out_valid, 1'b0);
        repeat (2) tick();
        query("flush_hs_trained", 16'h0005, 1'b1);
        query("flush_hs_dropped", 16'h0006, 1'b0);

        // Non-branch and J never train the predictor
        do_reset();
        out_ready = 1'b1;
        drive(5'b00000, 16'h0000, 16'h0008, 1'b1);
        tick();
        check("nonbr_is_branch", out_is_branch, 1'b0);
        check("nonbr_taken", out_taken, 1'b0);
        check("nonbr_mispredict", out_mispredict, 1'b0);
        drive(T_J, 16'h0000, 16'h0008, 1'b0);
        tick();
        check("j_is_branch", out_is_branch, 1'b1);
        check("j_taken", out_taken, 1'b1);
        check("j_mispredict", out_mispredict, 1'b1);
        drive(T_J, 16'h0000, 16'h0008, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        query("j_bht_unchanged", 16'h0008, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
